// File: rtl/segre_store_buffer.sv
// FIFO of committed stores between TL and the D-cache write port, with load forwarding.
// Optional build macro SEGRE_SB_COALESCE_EN merges a store into a matching youngest entry.

`ifndef STORE_BUFFER_NUM_ELEMS
`define STORE_BUFFER_NUM_ELEMS 2
`endif

module segre_store_buffer #(
    parameter int NUM_ELEMS = `STORE_BUFFER_NUM_ELEMS,
    parameter int ADDR_SIZE = 32,
    parameter int WORD_SIZE = 32
) (
    input  logic                 clk_i,
    input  logic                 rsn_i,
    input  logic                 req_store_i,
    input  logic                 req_load_i,
    input  logic                 flush_chance_i,
    input  logic [ADDR_SIZE-1:0] addr_i,
    input  logic [WORD_SIZE-1:0] data_i,
    input  logic [1:0]           memop_data_type_i,
    output logic                 hit_o,
    output logic                 miss_o,
    output logic                 trouble_o,
    output logic                 full_o,
    output logic [WORD_SIZE-1:0] data_load_o,
    output logic                 data_valid_o,
    output logic [ADDR_SIZE-1:0] addr_o,
    output logic [WORD_SIZE-1:0] data_flush_o,
    output logic [1:0]           memop_data_type_o
);
    localparam int PTR_W = $clog2(NUM_ELEMS);
    localparam logic [1:0] BYTE = 2'b00;
    localparam logic [1:0] HALF = 2'b01;

    logic [ADDR_SIZE-1:0] addr_q [NUM_ELEMS];
    logic [ADDR_SIZE-1:0] addr_d [NUM_ELEMS];
    logic [WORD_SIZE-1:0] data_q [NUM_ELEMS];
    logic [WORD_SIZE-1:0] data_d [NUM_ELEMS];
    logic [1:0]           type_q [NUM_ELEMS];
    logic [1:0]           type_d [NUM_ELEMS];
    logic [NUM_ELEMS-1:0] valid_q, valid_d;
    logic [PTR_W-1:0]     head_q, head_d, tail_q, tail_d;
    logic [PTR_W:0]       count_q, count_d;

    logic                 full, not_empty, pop, push, coalesce;
    logic                 trouble_any, exact_any;
    logic [WORD_SIZE-1:0] fwd_data;
    logic [3:0]           ld_mask;
    logic [PTR_W-1:0]     idx;

    function automatic logic [3:0] byte_mask(input logic [1:0] t, input logic [1:0] off);
        case (t)
            BYTE:    byte_mask = 4'b0001 << off;
            HALF:    byte_mask = 4'b0011 << off;
            default: byte_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic [WORD_SIZE-1:0] width_mask(input logic [1:0] t);
        case (t)
            BYTE:    width_mask = WORD_SIZE'(8'hFF);
            HALF:    width_mask = WORD_SIZE'(16'hFFFF);
            default: width_mask = '1;
        endcase
    endfunction

    assign full      = (count_q == (PTR_W+1)'(NUM_ELEMS));
    assign not_empty = (count_q != '0);
    assign pop       = flush_chance_i && not_empty;

`ifdef SEGRE_SB_COALESCE_EN
    logic [PTR_W-1:0] youngest;
    assign youngest = tail_q - PTR_W'(1);
    // The youngest entry can only be the popped head when it is the sole entry.
    assign coalesce = req_store_i && not_empty && valid_q[youngest]
                      && (addr_q[youngest] == addr_i)
                      && (type_q[youngest] == memop_data_type_i)
                      && !(pop && (count_q == (PTR_W+1)'(1)));
`else
    assign coalesce = 1'b0;
`endif

    assign push = req_store_i && !full && !coalesce;

    always_comb begin
        addr_d  = addr_q;
        data_d  = data_q;
        type_d  = type_q;
        valid_d = valid_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PTR_W'(1);
        end
        if (push) begin
            addr_d[tail_q]  = addr_i;
            data_d[tail_q]  = data_i;
            type_d[tail_q]  = memop_data_type_i;
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + PTR_W'(1);
        end
        if (coalesce) begin
            data_d[tail_q - PTR_W'(1)] = data_i;
        end
        if (push && !pop) begin
            count_d = count_q + (PTR_W+1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            for (int i = 0; i < NUM_ELEMS; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                type_q[i] <= BYTE;
            end
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            addr_q  <= addr_d;
            data_q  <= data_d;
            type_q  <= type_d;
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Walk oldest to youngest so the last exact match seen is the youngest one.
    always_comb begin
        trouble_any = 1'b0;
        exact_any   = 1'b0;
        fwd_data    = '0;
        idx         = '0;
        ld_mask     = byte_mask(memop_data_type_i, addr_i[1:0]);
        for (int i = 0; i < NUM_ELEMS; i++) begin
            idx = head_q + PTR_W'(i);
            if (valid_q[idx] && (addr_q[idx][ADDR_SIZE-1:2] == addr_i[ADDR_SIZE-1:2])
                && ((byte_mask(type_q[idx], addr_q[idx][1:0]) & ld_mask) != 4'b0000)) begin
                if ((addr_q[idx] == addr_i) && (type_q[idx] == memop_data_type_i)) begin
                    exact_any = 1'b1;
                    fwd_data  = data_q[idx] & width_mask(type_q[idx]);
                end else begin
                    trouble_any = 1'b1;
                end
            end
        end
    end

    assign trouble_o         = rsn_i && req_load_i && trouble_any;
    assign hit_o             = rsn_i && req_load_i && !trouble_any && exact_any;
    assign miss_o            = rsn_i && req_load_i && !trouble_any && !exact_any;
    assign data_load_o       = hit_o ? fwd_data : '0;
    assign full_o            = rsn_i && full;
    assign data_valid_o      = rsn_i && not_empty;
    assign addr_o            = data_valid_o ? addr_q[head_q] : '0;
    assign data_flush_o      = data_valid_o ? data_q[head_q] : '0;
    assign memop_data_type_o = data_valid_o ? type_q[head_q] : BYTE;

endmodule

// File: tb/tb_segre_store_buffer.sv
// Directed self-checking bench for segre_store_buffer; honours SEGRE_SB_COALESCE_EN.

module tb_segre_store_buffer;
    localparam logic [1:0] BYTE = 2'b00;
    localparam logic [1:0] WORD = 2'b10;

    logic        clk_i = 1'b0;
    logic        rsn_i;
    logic        req_store_i, req_load_i, flush_chance_i;
    logic [31:0] addr_i, data_i;
    logic [1:0]  memop_data_type_i;
    logic        hit_o, miss_o, trouble_o, full_o, data_valid_o;
    logic [31:0] data_load_o, addr_o, data_flush_o;
    logic [1:0]  memop_data_type_o;

    int testCount  = 0;
    int failCount  = 0;
    int pushFullCount = 0;

    segre_store_buffer dut (
        .clk_i(clk_i), .rsn_i(rsn_i), .req_store_i(req_store_i), .req_load_i(req_load_i),
        .flush_chance_i(flush_chance_i), .addr_i(addr_i), .data_i(data_i),
        .memop_data_type_i(memop_data_type_i), .hit_o(hit_o), .miss_o(miss_o),
        .trouble_o(trouble_o), .full_o(full_o), .data_load_o(data_load_o),
        .data_valid_o(data_valid_o), .addr_o(addr_o), .data_flush_o(data_flush_o),
        .memop_data_type_o(memop_data_type_o)
    );

    always #5 clk_i = ~clk_i;

    // Records every store presented while the buffer reports full.
    always @(posedge clk_i) begin
        if (rsn_i && req_store_i && full_o) pushFullCount++;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic ld, input logic fl,
                                 input logic [31:0] a, input logic [31:0] d, input logic [1:0] t);
        req_store_i = st; req_load_i = ld; flush_chance_i = fl;
        addr_i = a; data_i = d; memop_data_type_i = t;
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, BYTE);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rsn_i = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h100, 32'h0, WORD);
        checkOutput("rst_full", full_o, 0);
        checkOutput("rst_valid", data_valid_o, 0);
        checkOutput("rst_miss_gated", miss_o, 0);
        checkOutput("rst_addr", addr_o, 0);
        tick();
        rsn_i = 1'b1;
        idle();
        tick();
        checkOutput("idle_flags", {hit_o, miss_o, trouble_o}, 3'b000);

        // Fill and drain
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h100, 32'hDEADBEEF, WORD);
        tick();
        checkOutput("one_entry_not_full", full_o, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h104, 32'h12345678, WORD);
        tick();
        idle();
        checkOutput("fill_full", full_o, 1);
        checkOutput("fill_head_data", data_flush_o, 32'hDEADBEEF);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h104, 32'h0, WORD);
        checkOutput("fill_load_hit", {hit_o, miss_o, trouble_o}, 3'b100);
        checkOutput("fill_load_data", data_load_o, 32'h12345678);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, BYTE);
        checkOutput("drain_addr0", addr_o, 32'h100);
        tick();
        checkOutput("drain_addr1", addr_o, 32'h104);
        checkOutput("drain_not_full", full_o, 0);
        tick();
        idle();
        checkOutput("drain_empty", data_valid_o, 0);
        checkOutput("drain_idle_addr", addr_o, 0);
        checkOutput("drain_idle_type", memop_data_type_o, BYTE);

        // Forward from youngest
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h200, 32'hAAAA5555, WORD);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h200, 32'h11112222, WORD);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h200, 32'h0, WORD);
        checkOutput("fwd_hit", {hit_o, miss_o, trouble_o}, 3'b100);
        checkOutput("fwd_data", data_load_o, 32'h11112222);
`ifdef SEGRE_SB_COALESCE_EN
        checkOutput("fwd_coalesced_not_full", full_o, 0);
`else
        checkOutput("fwd_two_entries_full", full_o, 1);
`endif
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, BYTE);
        tick();
        tick();
        idle();
        checkOutput("fwd_drained", data_valid_o, 0);

        // Partial overlap
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h300, 32'h12345678, WORD);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h302, 32'h0, BYTE);
        checkOutput("partial_trouble", {hit_o, miss_o, trouble_o}, 3'b001);
        checkOutput("partial_no_data", data_load_o, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h304, 32'h0, BYTE);
        checkOutput("partial_miss", {hit_o, miss_o, trouble_o}, 3'b010);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h300, 32'h0, BYTE);
        checkOutput("partial_type_differs", {hit_o, miss_o, trouble_o}, 3'b001);

        // Simultaneous push and pop with one entry (0x300) buffered
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h400, 32'hCAFEF00D, WORD);
        checkOutput("pp_head_before", addr_o, 32'h300);
        checkOutput("pp_push_invisible", {hit_o, miss_o, trouble_o}, 3'b010);
        tick();
        idle();
        checkOutput("pp_valid", data_valid_o, 1);
        checkOutput("pp_not_full", full_o, 0);
        checkOutput("pp_new_head", addr_o, 32'h400);
        checkOutput("pp_new_data", data_flush_o, 32'hCAFEF00D);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, BYTE);
        tick();
        idle();
        checkOutput("pp_count_one", data_valid_o, 0);

        // Reset mid-operation
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h100, 32'hDEADBEEF, WORD);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h104, 32'h12345678, WORD);
        tick();
        idle();
        checkOutput("mid_full_before", full_o, 1);
        rsn_i = 1'b0;
        #1;
        checkOutput("mid_full_drop", full_o, 0);
        checkOutput("mid_valid_drop", data_valid_o, 0);
        tick();
        rsn_i = 1'b1;
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h100, 32'h0, WORD);
        checkOutput("mid_after_miss", {hit_o, miss_o, trouble_o}, 3'b010);

        // Coalescing / push while full
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h500, 32'h11111111, WORD);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h504, 32'h22222222, WORD);
        tick();
        checkOutput("co_full", full_o, 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h504, 32'h33333333, WORD);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h504, 32'h0, WORD);
        checkOutput("co_hit", {hit_o, miss_o, trouble_o}, 3'b100);
`ifdef SEGRE_SB_COALESCE_EN
        checkOutput("co_data_new", data_load_o, 32'h33333333);
`else
        checkOutput("co_data_dropped", data_load_o, 32'h22222222);
`endif
        checkOutput("co_still_full", full_o, 1);
        checkOutput("co_head_kept", addr_o, 32'h500);
        checkOutput("push_while_full_seen", pushFullCount, 1);
        idle();

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end
endmodule

// File: doc/segre_store_buffer.md
# segre_store_buffer

Small FIFO of committed stores sitting between the TL stage and the data cache write port in the MEM stage. TL pushes stores into it instead of writing the cache directly, and looks up loads against it for store-to-load forwarding or hazard detection. MEM drains the oldest entry into the D-cache whenever the cache port is free (`flush_chance_i`).

## Interface
- `NUM_ELEMS`, default `STORE_BUFFER_NUM_ELEMS` (2): entry count. Must be a power of 2 and at least 2.
- `ADDR_SIZE`, default 32: address width.
- `WORD_SIZE`, default 32: data width.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge
- `rsn_i`  in  1  reset, asynchronous, active-low
- `req_store_i`  in  1  push a store (addr/data/type) this cycle
- `req_load_i`  in  1  look up a load (addr/type) this cycle
- `flush_chance_i`  in  1  D-cache write port free; pop the head if one is valid
- `addr_i`  in  ADDR_SIZE  store or load address
- `data_i`  in  WORD_SIZE  store data, right-aligned
- `memop_data_type_i`  in  2  BYTE/HALF/WORD (`memop_data_type_e`)
- `hit_o`  out  1  load fully forwarded from the buffer
- `miss_o`  out  1  load overlaps no entry
- `trouble_o`  out  1  load partially overlaps an entry; TL must stall until drained
- `full_o`  out  1  count == NUM_ELEMS
- `data_load_o`  out  WORD_SIZE  forwarded data, right-aligned and unextended
- `data_valid_o`  out  1  head entry valid, i.e. count != 0
- `addr_o`  out  ADDR_SIZE  head address
- `data_flush_o`  out  WORD_SIZE  head data
- `memop_data_type_o`  out  2  head type

## Operation
- **Storage:** circular array of {addr, data, type, valid}, with head/tail pointers of width log2(NUM_ELEMS) and a count of 0..NUM_ELEMS. Pointers wrap modulo NUM_ELEMS.
- **Push:** accepted when `req_store_i && !full_o`. Writes at tail, then tail+1 and count+1.
  - A store while full is dropped. TL is required to stall on `full_o`.
  - Verification flags any push-while-full as an assertion failure.
- **Pop:** when `flush_chance_i && data_valid_o`, head+1 and count-1. MEM writes `addr_o`/`data_flush_o`/`memop_data_type_o` to the cache in that same cycle.
- **Push and pop in the same cycle:** both take effect and count is unchanged. A push is never accepted on `full_o`, even if a pop happens that cycle.
- **Load lookup** is combinational against the pre-edge valid entries. A same-cycle push is not visible.
- **Byte mask:** derived from the type and `addr[1:0]` (BYTE=1, HALF=2, WORD=4 bytes). An entry overlaps a load when `addr[ADDR_SIZE-1:2]` is equal and the masks intersect.
- **Exact match:** same full address and same type.
- **Lookup priority:**
  1. Any overlapping entry that is not an exact match sets `trouble_o`=1.
  2. Otherwise, any exact match sets `hit_o`=1, with `data_load_o` taken from the youngest exact match.
  3. Otherwise `miss_o`=1.
- **One-hot flags:** exactly one of hit/miss/trouble is 1 while `req_load_i`=1. All three are 0 otherwise.
- **Idle outputs:** `data_load_o`=0 when not hit. `addr_o`/`data_flush_o`=0 and `memop_data_type_o`=BYTE when empty.
- **Reset** (asynchronous, any cycle, including mid-push or mid-pop):
  - All valid bits, pointers and count go to 0. Buffered stores are discarded.
  - Every output reads 0 (types read BYTE) while `rsn_i`=0.

## Timing
- Lookup has 0-cycle latency: hit/miss/trouble/`data_load_o` are valid in the same cycle as `req_load_i`.
- A pushed store becomes visible to lookup, `data_valid_o` and `full_o` from the cycle after the push edge.
- A popped entry disappears the cycle after the pop edge. A load in the pop cycle still sees it.
- No multi-cycle handshakes; all control is single-cycle qualified by the request inputs.

## Configuration
- **With `SEGRE_SB_COALESCE_EN` defined:** a store that exactly matches the youngest valid entry overwrites that entry's data in place, without allocating.
  - This applies only when that entry is not the head being popped this cycle.
  - Such a store is accepted even when `full_o`=1, and count is unchanged.
- **Without the macro:** every accepted store allocates a new entry.

## Test plan
- **Fill and drain:** reset, then push WORD 0x100=0xDEADBEEF and WORD 0x104=0x12345678.
  - `full_o`=1 the next cycle.
  - Two `flush_chance_i` cycles present 0x100 then 0x104 on `addr_o`.
  - `data_valid_o`=0 afterwards.
- **Forward from the youngest entry:** push WORD 0x200=0xAAAA5555, then WORD 0x200=0x11112222. A WORD load at 0x200 gives `hit_o`=1 and `data_load_o`=0x11112222.
- **Partial overlap:** with WORD 0x300 buffered, a BYTE load at 0x302 gives `trouble_o`=1. A BYTE load at 0x304 gives `miss_o`=1.
- **Simultaneous push and pop:** with 1 entry buffered, assert store and flush together. Count stays 1, and the new entry becomes the head the next cycle.
- **Reset mid-operation:** deassert `rsn_i` with 2 entries buffered. `full_o`/`data_valid_o` drop to 0 immediately, and a WORD load at 0x100 after reset gives `miss_o`=1.
- **Coalescing:**
  - With `SEGRE_SB_COALESCE_EN`: when full, a store to the tail's address/type is accepted, and a load then returns the new data.
  - Without the macro: the same store is dropped, and the assertion check flags the push-while-full.
